serial_add_seq: RTL
===================

Name: serial_add_seq

Overview:
- Bit-serial adder sequencer. Accepts two WIDTH-bit operands and a carry-in, and adds them LSB-first, one bit per clock.
- The datapath is a single 1-bit full-adder cell. Its carry is registered between cycles.
- Sits upstream of the 1-bit full-adder stage: it feeds the cell its A/B/Cin bits each cycle and collects its sum/carry outputs.
- Gives the TinyTapeout top a multi-bit add built from the existing 1-bit adder.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; holds the last completed value.
- cout  output  1  final carry-out; holds the last completed value.
- sub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN.

Interface rule (already decided): one clock `clk`; reset `rst` is synchronous and active-high.

Behaviour:
- Reset (rst=1 at an edge):
  - state := IDLE.
  - busy, done, sum, cout := 0.
  - Bit counter, operand shift registers and carry register := 0.
  - rst has priority over every other input, including mid-RUN; a partial result is discarded and sum/cout are not updated.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E: load a, b and cin into internal shift registers; counter := 0; go to RUN.
  - start=0: stay in IDLE.
- RUN: each edge E+1..E+WIDTH processes one bit:
  - s = a_sh[0] ^ b_sh[0] ^ c.
  - c := majority(a_sh[0], b_sh[0], c).
  - s shifts into the MSB of the internal result register; a_sh and b_sh shift right.
  - Counter increments each bit.
- Last bit (edge E+WIDTH):
  - Copy the internal result into sum and the final carry into cout.
  - Go to DONE.
- DONE: lasts exactly one cycle with done=1, then unconditionally returns to IDLE.
- busy:
  - 1 in RUN and DONE, i.e. for WIDTH+1 cycles after the accepting edge.
  - 0 in IDLE.
- Latency: done is high during the cycle following edge E+WIDTH (WIDTH cycles after start is accepted).
  - Back-to-back: start held high in the cycle after done is accepted at the next edge. Throughput is one operation per WIDTH+2 cycles.
- start while busy=1: ignored, no queuing. a/b/cin may change freely during RUN without effect.
- sum and cout change only on the completion edge. They hold between operations.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Port `sub` exists and is captured with the operands on an accepted start.
  - sub=1: b is inverted at load and the carry register is forced to 1, so cin is ignored. Result is a - b in two's complement.
  - cout = 1 means no borrow (a >= b unsigned).
  - sub=0: behaviour identical to the undefined build.
- Undefined:
  - Port `sub` absent; add-only.
  - No extra logic is synthesized.

Test Plan (WIDTH=4):
- Reset, then start with a=5, b=3, cin=0 → busy rises after the edge; done pulses exactly 4 cycles later; sum=8, cout=0; busy low the following cycle.
- a=15, b=1, cin=0 → sum=0, cout=1. Then a=15, b=15, cin=1 → sum=15, cout=1. Outputs hold between runs.
- Start accepted with a=2, b=2; pulse start again with a=7, b=7 at RUN cycle 2 → second start ignored; result sum=4, cout=0; only one done pulse.
- Start with a=9, b=9, previous result sum=8; assert rst at RUN cycle 2 → next cycle busy=0, done=0, sum=0, cout=0. A new start with a=1, b=1 then yields sum=2.
- Back-to-back: start held high continuously with a=6, b=1 → done pulses every 6 cycles; sum=7 each time; no missed or double completions.
- With SERIAL_ADD_SUB_EN:
  - sub=1, a=3, b=5 → sum=14, cout=0.
  - sub=1, a=5, b=3 → sum=2, cout=1.
  - sub=0, a=5, b=3, cin=1 → sum=9, cout=0.

Source files
------------

// File: rtl/serial_add_seq.sv
// rtl/serial_add_seq.sv - bit-serial adder sequencer built around a single 1-bit full-adder cell
//
// Adds two WIDTH-bit operands plus a carry-in, LSB first, one bit per clock.
// The carry is registered between bit cycles. The result and the final carry
// are published together on the completion edge, and they hold until the next completion.
//
// Optional build macro: SERIAL_ADD_SUB_EN
//   When defined, the design adds the `sub` input. With sub=1, operand b is
//   inverted at load and the carry is forced to 1, so the result is a - b
//   in two's complement. In that mode cout=1 means no borrow.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request pulse, sampled only in IDLE
//   a, b   in   WIDTH-bit operands, captured on an accepted start
//   cin    in   carry-in, captured on an accepted start
//   sub    in   subtract select (SERIAL_ADD_SUB_EN builds only)
//   busy   out  high in RUN and DONE
//   done   out  one-cycle completion pulse
//   sum    out  last completed result
//   cout   out  last completed carry-out

module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             last_bit;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // The 1-bit full-adder cell is fed from the low bits of the shift registers.
    assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // New sum bits enter at the MSB. After WIDTH shifts, the first bit
    // (the LSB) has reached bit 0.
    assign res_next = {fa_s, res_sh[WIDTH-1:1]};

    assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1, so the forced carry replaces cin.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, serial bit processing, result publication.
    // On reset, any partial result is discarded along with the published one.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b_load;
                        carry  <= c_load;
                        res_sh <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    carry  <= fa_c;
                    res_sh <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= res_next;
                        cout <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
